// File: rtl/sn76489_register_decoder.sv
// SN76489 PSG write port: decodes latch/data bytes into tone periods, attenuations
// and noise control, and models the READY busy window after each accepted write.
module sn76489_register_decoder #(
  parameter int READY_CYCLES = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       ready,
  output logic [9:0] tone0_n,
  output logic [9:0] tone1_n,
  output logic [9:0] tone2_n,
  output logic [9:0] noise_n,
  output logic [1:0] noise_feed,
  output logic       noise_type,
  output logic       noise_reset,
  output logic [3:0] att0,
  output logic [3:0] att1,
  output logic [3:0] att2,
  output logic [3:0] att3
);

  localparam int CW_RAW = $clog2(READY_CYCLES + 1);
  localparam int CW = (CW_RAW < 1) ? 1 : CW_RAW;
  localparam logic [CW-1:0] BUSY_LOAD = CW'(READY_CYCLES);

  // Handshake: a write is taken on any rising clk where wr_en && ready; ready then
  // drops for READY_CYCLES cycles. Writes presented while ready is low are discarded.
  logic          accept;
  logic [CW-1:0] busy_cnt;

  logic [1:0]    latch_ch;
  logic          latch_vol;
  logic [1:0]    tgt_ch;
  logic          tgt_vol;

  logic [9:0]    tone [3];
  logic [3:0]    att  [4];

  assign ready  = (busy_cnt == '0);
  assign accept = wr_en && ready;

  // Latch bytes name their own target; data bytes reuse the latched one.
  always_comb begin
    tgt_ch  = latch_ch;
    tgt_vol = latch_vol;
    if (wr_data[7]) begin
      tgt_ch  = wr_data[6:5];
      tgt_vol = wr_data[4];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_cnt    <= '0;
      latch_ch    <= 2'd0;
      latch_vol   <= 1'b0;
      noise_feed  <= 2'd0;
      noise_type  <= 1'b0;
      noise_reset <= 1'b0;
      noise_n     <= 10'h010;
      for (int i = 0; i < 3; i++) tone[i] <= 10'd0;
      for (int i = 0; i < 4; i++) att[i] <= 4'hF;
    end else begin
      noise_reset <= 1'b0;
      // Derived from registered settings, so it lands one cycle after them.
      case (noise_feed)
        2'd0:    noise_n <= 10'h010;
        2'd1:    noise_n <= 10'h020;
        2'd2:    noise_n <= 10'h040;
        default: noise_n <= tone[2];
      endcase

      if (busy_cnt != '0) busy_cnt <= busy_cnt - 1'b1;

      if (accept) begin
        busy_cnt <= BUSY_LOAD;
        if (wr_data[7]) begin
          latch_ch  <= wr_data[6:5];
          latch_vol <= wr_data[4];
        end
        if (tgt_vol) begin
          for (int i = 0; i < 4; i++)
            if (tgt_ch == 2'(i)) att[i] <= wr_data[3:0];
        end else if (tgt_ch == 2'd3) begin
          noise_type  <= wr_data[2];
          noise_feed  <= wr_data[1:0];
          noise_reset <= 1'b1;
        end else begin
          for (int i = 0; i < 3; i++) begin
            if (tgt_ch == 2'(i)) begin
              if (wr_data[7]) tone[i][3:0] <= wr_data[3:0];
              else            tone[i][9:4] <= wr_data[5:0];
            end
          end
        end
      end
    end
  end

  assign tone0_n = tone[0];
  assign tone1_n = tone[1];
  assign tone2_n = tone[2];
  assign att0    = att[0];
  assign att1    = att[1];
  assign att2    = att[2];
  assign att3    = att[3];

endmodule

// File: tb/tb_sn76489_register_decoder.sv
// Bench for sn76489_register_decoder: directed protocol steps plus random bytes,
// checked against a register-map model of the PSG write protocol.
module tb_sn76489_register_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       ready;
  logic [9:0] tone0_n, tone1_n, tone2_n, noise_n;
  logic [1:0] noise_feed;
  logic       noise_type, noise_reset;
  logic [3:0] att0, att1, att2, att3;

  logic       wr_en_b;
  logic [7:0] wr_data_b;
  logic       ready_b;
  logic [9:0] b_tone0_n, b_tone1_n, b_tone2_n, b_noise_n;
  logic [1:0] b_noise_feed;
  logic       b_noise_type, b_noise_reset;
  logic [3:0] b_att0, b_att1, b_att2, b_att3;

  sn76489_register_decoder #(.READY_CYCLES(32)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .ready(ready),
    .tone0_n(tone0_n), .tone1_n(tone1_n), .tone2_n(tone2_n), .noise_n(noise_n),
    .noise_feed(noise_feed), .noise_type(noise_type), .noise_reset(noise_reset),
    .att0(att0), .att1(att1), .att2(att2), .att3(att3)
  );

  sn76489_register_decoder #(.READY_CYCLES(0)) dut_b (
    .clk(clk), .reset(reset), .wr_en(wr_en_b), .wr_data(wr_data_b), .ready(ready_b),
    .tone0_n(b_tone0_n), .tone1_n(b_tone1_n), .tone2_n(b_tone2_n), .noise_n(b_noise_n),
    .noise_feed(b_noise_feed), .noise_type(b_noise_type), .noise_reset(b_noise_reset),
    .att0(b_att0), .att1(b_att1), .att2(b_att2), .att3(b_att3)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the PSG register map as the programmer sees it.
  logic [9:0] m_tone [3];
  logic [3:0] m_att  [4];
  int         m_ch;
  bit         m_vol;
  logic [1:0] m_feed;
  logic       m_type;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] m_noise_n();
    if (m_feed == 2'd3) return m_tone[2];
    return 10'h010 << m_feed;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) m_tone[i] = 10'd0;
    for (int i = 0; i < 4; i++) m_att[i] = 4'hF;
    m_ch = 0; m_vol = 0; m_feed = 2'd0; m_type = 1'b0;
  endtask

  task automatic model_write(input logic [7:0] b, output bit pulse);
    pulse = 0;
    if (b[7]) begin
      m_ch  = int'(b[6:5]);
      m_vol = b[4];
    end
    if (m_vol) m_att[m_ch] = b[3:0];
    else if (m_ch == 3) begin
      m_type = b[2];
      m_feed = b[1:0];
      pulse  = 1;
    end else if (b[7]) m_tone[m_ch][3:0] = b[3:0];
    else m_tone[m_ch][9:4] = b[5:0];
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".tone0"}, 32'(tone0_n), 32'(m_tone[0]));
    check({tag, ".tone1"}, 32'(tone1_n), 32'(m_tone[1]));
    check({tag, ".tone2"}, 32'(tone2_n), 32'(m_tone[2]));
    check({tag, ".att"}, {16'd0, att0, att1, att2, att3},
          {16'd0, m_att[0], m_att[1], m_att[2], m_att[3]});
    check({tag, ".feed"}, 32'(noise_feed), 32'(m_feed));
    check({tag, ".type"}, 32'(noise_type), 32'(m_type));
  endtask

  task automatic wait_ready();
    int guard = 0;
    while (!ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    check("ready_wait", 32'(ready), 32'd1);
  endtask

  task automatic do_write(input string tag, input logic [7:0] b);
    bit pulse;
    wait_ready();
    wr_data = b;
    wr_en   = 1'b1;
    @(posedge clk); #1;
    wr_en = 1'b0;
    model_write(b, pulse);
    check({tag, ".pulse"}, 32'(noise_reset), 32'(pulse));
    check({tag, ".busy"}, 32'(ready), 32'd0);
    check_regs(tag);
    @(posedge clk); #1;
    check({tag, ".pulse_end"}, 32'(noise_reset), 32'd0);
    check({tag, ".noise_n"}, 32'(noise_n), 32'(m_noise_n()));
  endtask

  initial begin
    logic [7:0] seq_b [6];
    int low_cycles;

    wr_en_b = 1'b0; wr_data_b = 8'h00;
    reset = 1'b1; wr_en = 1'b1; wr_data = 8'hE4;
    model_reset();
    repeat (2) begin
      @(posedge clk); #1;
      check("rst.pulse", 32'(noise_reset), 32'd0);
    end
    reset = 1'b0; wr_en = 1'b0;
    check("rst.ready", 32'(ready), 32'd1);
    check("rst.noise_n", 32'(noise_n), 32'h010);
    check_regs("rst");

    // Data byte with no prior latch goes to tone0 high bits.
    do_write("data_first", 8'h05);
    do_write("tone_lo", 8'h8E);
    do_write("tone_hi", 8'h0F);
    check("tone0_fe", 32'(tone0_n), 32'h0FE);

    do_write("vol_latch", 8'hBA);
    do_write("vol_data", 8'h03);
    check("att1_3", 32'(att1), 32'h3);

    do_write("noise_latch", 8'hE5);
    do_write("noise_data", 8'h02);
    check("noise_n_40", 32'(noise_n), 32'h040);

    do_write("feed3", 8'hE7);
    do_write("t2_lo", 8'hC5);
    do_write("t2_hi", 8'h12);
    check("noise_n_125", 32'(noise_n), 32'h125);

    // Strobe during busy must be ignored; measure the busy window.
    do_write("att0_f", 8'h9F);
    wr_data = 8'h90; wr_en = 1'b1;
    @(posedge clk); #1;
    wr_en = 1'b0;
    check("drop.pulse", 32'(noise_reset), 32'd0);
    low_cycles = 2;
    while (!ready && low_cycles < 100) begin
      @(posedge clk); #1;
      low_cycles++;
    end
    check("busy_len", 32'(low_cycles), 32'd32);
    check_regs("drop");

    for (int i = 0; i < 40; i++)
      do_write("rand", 8'($urandom_range(0, 255)));
    wait_ready();
    check_regs("rand_end");

    // Reset in the middle of a busy window.
    do_write("pre_rst", 8'h83);
    repeat (5) @(posedge clk);
    #1;
    check("mid_busy", 32'(ready), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    check("rst_mid.ready", 32'(ready), 32'd1);
    check("rst_mid.pulse", 32'(noise_reset), 32'd0);
    check_regs("rst_mid");
    @(posedge clk); #1;
    check("rst_mid.noise_n", 32'(noise_n), 32'h010);

    // Zero busy time: one write per cycle, back to back.
    seq_b = '{8'hA3, 8'h15, 8'hC7, 8'h22, 8'hE4, 8'h03};
    wr_en_b = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wr_data_b = seq_b[i];
      @(posedge clk); #1;
      check("b.ready", 32'(ready_b), 32'd1);
      check("b.pulse", 32'(b_noise_reset), (i >= 4) ? 32'd1 : 32'd0);
    end
    wr_en_b = 1'b0;
    check("b.tone1", 32'(b_tone1_n), 32'h153);
    check("b.tone2", 32'(b_tone2_n), 32'h227);
    check("b.feed", 32'(b_noise_feed), 32'd3);
    check("b.type", 32'(b_noise_type), 32'd0);
    @(posedge clk); #1;
    check("b.pulse_end", 32'(b_noise_reset), 32'd0);
    check("b.noise_n", 32'(b_noise_n), 32'h227);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
